// File: rtl/gpio_in_filter.sv
// Pad input conditioning: synchronizer, optional per-bit debounce on a shared
// prescaled sample tick, and registered rise/fall pulses.
module gpio_in_filter #(
    parameter int Width        = 32,
    parameter int SyncStages   = 2,
    parameter int FilterCycles = 4,
    parameter int PrescaleDiv  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] pad_din_i,
    input  logic [Width-1:0] filter_en_i,
    output logic [Width-1:0] gpio_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    localparam int CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
    localparam int PreW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);
    localparam logic [PreW-1:0] PreMax = PreW'(PrescaleDiv - 1);

    generate
        if (SyncStages < 2) begin : g_bad_sync
            $error("gpio_in_filter: SyncStages must be at least 2");
        end
        if (FilterCycles < 1) begin : g_bad_filter
            $error("gpio_in_filter: FilterCycles must be at least 1");
        end
        if (PrescaleDiv < 1) begin : g_bad_prescale
            $error("gpio_in_filter: PrescaleDiv must be at least 1");
        end
    endgenerate

    logic [SyncStages-1:0][Width-1:0] sync_q;
    logic [Width-1:0]                 s;
    logic [PreW-1:0]                  pre_q;
    logic                             tick;
    logic [Width-1:0][CntW-1:0]       cnt_q;
    logic [Width-1:0][CntW-1:0]       cnt_d;
    logic [Width-1:0]                 gpio_d;

    assign s    = sync_q[SyncStages-1];
    assign tick = (pre_q == PreMax);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pad_din_i};
        end
    end

    // Free-running; pad activity never realigns the sample phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    always_comb begin
        gpio_d = gpio_o;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < Width; i++) begin
            if (!filter_en_i[i]) begin
                gpio_d[i] = s[i];
                cnt_d[i]  = '0;
            end else if (tick) begin
                if (s[i] == gpio_o[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    gpio_d[i] = s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Pulses derive from the next level so they coincide with the new gpio_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            gpio_o <= '0;
            rise_o <= '0;
            fall_o <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gpio_o <= gpio_d;
            rise_o <= gpio_d & ~gpio_o;
            fall_o <= ~gpio_d & gpio_o;
        end
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: one instance at PrescaleDiv=1 and one at
// PrescaleDiv=4, both with FilterCycles=4 and shared stimulus.
module tb_gpio_in_filter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pad_din_i;
    logic [31:0] filter_en_i;
    logic [31:0] gpio_o, rise_o, fall_o;
    logic [31:0] gpio_p, rise_p, fall_p;

    int checks = 0;
    int errors = 0;

    gpio_in_filter #(.Width(32), .SyncStages(2), .FilterCycles(4), .PrescaleDiv(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pad_din_i(pad_din_i), .filter_en_i(filter_en_i),
        .gpio_o(gpio_o), .rise_o(rise_o), .fall_o(fall_o)
    );

    gpio_in_filter #(.Width(32), .SyncStages(2), .FilterCycles(4), .PrescaleDiv(4)) dut_p (
        .clk_i(clk_i), .rst_i(rst_i), .pad_din_i(pad_din_i), .filter_en_i(filter_en_i),
        .gpio_o(gpio_p), .rise_o(rise_p), .fall_o(fall_p)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] acc;
        int          lat;
        logic        exp_lvl;

        // 1: reset release in bypass with all pads high
        rst_i       = 1'b1;
        pad_din_i   = 32'hFFFF_FFFF;
        filter_en_i = '0;
        step(); step(); step();
        check("rst_gpio", gpio_o, 32'h0);
        check("rst_rise", rise_o, 32'h0);
        rst_i = 1'b0;
        step(); step();
        check("byp_e2_gpio", gpio_o, 32'h0);
        step();
        check("byp_e3_gpio", gpio_o, 32'hFFFF_FFFF);
        check("byp_e3_rise", rise_o, 32'hFFFF_FFFF);
        step();
        check("byp_e4_rise", rise_o, 32'h0);

        pad_din_i = '0;
        step(); step(); step();
        check("byp_fall", fall_o, 32'hFFFF_FFFF);
        check("byp_low", gpio_o, 32'h0);

        // 2: filtered step on bit 0
        filter_en_i = '1;
        step(); step();
        pad_din_i = 32'h1;
        for (int k = 1; k <= 5; k++) step();
        check("flt_e5_gpio", gpio_o, 32'h0);
        step();
        check("flt_e6_gpio", gpio_o, 32'h1);
        check("flt_e6_rise", rise_o, 32'h1);
        step();
        check("flt_e7_rise", rise_o, 32'h0);

        // 3: 3-cycle glitch on bit 3 rejected, 4-cycle pulse accepted
        pad_din_i = 32'h9;
        acc = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) pad_din_i = 32'h1;
            acc = acc | rise_o | fall_o | (gpio_o ^ 32'h1);
        end
        check("glitch_reject", acc, 32'h0);
        pad_din_i = 32'h9;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) pad_din_i = 32'h1;
        end
        check("pulse4_e5_gpio", gpio_o, 32'h1);
        step();
        check("pulse4_e6_gpio", gpio_o, 32'h9);
        check("pulse4_e6_rise", rise_o, 32'h8);
        step(); step(); step(); step();
        check("pulse4_e10_fall", fall_o, 32'h8);
        check("pulse4_e10_gpio", gpio_o, 32'h1);

        // 4: prescaled step on bit 7 at varying prescaler phase
        for (int t = 0; t < 16; t++) begin
            int w;
            w = int'($urandom_range(0, 3));
            for (int k = 0; k < w; k++) step();
            exp_lvl = ~gpio_p[7];
            pad_din_i[7] = exp_lvl;
            lat = 0;
            while (gpio_p[7] != exp_lvl && lat < 30) begin
                step();
                lat++;
            end
            check($sformatf("presc_lat_ok_%0d", t), 32'((lat >= 15) && (lat <= 18)), 32'h1);
            check($sformatf("presc_edge_%0d", t), exp_lvl ? rise_p : fall_p, 32'h80);
        end
        step(); step();

        // 5: enable cleared while bit 2 falls with two ticks counted
        pad_din_i[2] = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check("en_pre_gpio2", 32'(gpio_o[2]), 32'h1);
        pad_din_i[2] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("en_mid_gpio2", 32'(gpio_o[2]), 32'h1);
        filter_en_i[2] = 1'b0;
        step();
        check("en_clr_gpio2", 32'(gpio_o[2]), 32'h0);
        check("en_clr_fall", fall_o, 32'h4);
        step();
        check("en_clr_fall_end", fall_o, 32'h0);
        filter_en_i[2] = 1'b1;
        step();
        pad_din_i[2] = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        check("en_set_e5_gpio2", 32'(gpio_o[2]), 32'h0);
        step();
        check("en_set_e6_gpio2", 32'(gpio_o[2]), 32'h1);

        // 6: asynchronous reset while counts are pending
        filter_en_i = '0;
        pad_din_i   = 32'hA5A5_A5A5;
        for (int k = 0; k < 5; k++) step();
        filter_en_i = '1;
        pad_din_i   = 32'h5A5A_5A5A;
        step(); step(); step();
        check("ar_pre_gpio", gpio_o, 32'hA5A5_A5A5);
        #2;
        rst_i = 1'b1;
        #1;
        check("ar_gpio", gpio_o, 32'h0);
        check("ar_edges", rise_o | fall_o, 32'h0);
        pad_din_i = '0;
        step(); step();
        rst_i = 1'b0;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            acc = acc | gpio_o | rise_o | fall_o;
        end
        check("ar_release_quiet", acc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
